ex_hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the RISC-V 5-stage CPU, centred on the EX stage: ALU, branch target adder and ALUSrc_B mux.
- Detects load-use hazards and generates registered forwarding selects for the EX operand inputs (Rs1, Rs2).
- Resolves taken branches/jumps from the EX zero flag, issuing PC redirect plus IF/ID and ID/EX flushes.
- Freezes the whole pipeline on data-memory wait, holding any redirect that resolves during the freeze.
- Sits beside the stage registers; drives their enables/flushes, the PC source mux and two EX-input forwarding muxes.

---
 rtl/ex_hazard_pkg.sv | 22 ++
 rtl/ex_hazard_ctrl_if.sv | 59 +++++
 rtl/ex_hazard_ctrl_fwd_sel_gen.sv | 46 ++++
 rtl/ex_hazard_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_ex_hazard_ctrl.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_hazard_pkg.sv
// ---------------------------------------------------------------------------
// ex_hazard_pkg
// Shared definitions for the EX-stage hazard / sequencing controller.
//   - Forwarding select encodings driven to the EX operand muxes.
//   - Controller FSM state type.
//   - Architectural zero register index (never a forwarding/hazard source).
// ---------------------------------------------------------------------------
package ex_hazard_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;  // operand from register file
  localparam logic [1:0] FWD_EXMEM = 2'b01;  // operand from EX/MEM ALU result
  localparam logic [1:0] FWD_MEMWB = 2'b10;  // operand from MEM/WB writeback

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    RUN          = 2'd0,
    FREEZE       = 2'd1,
    FREEZE_REDIR = 2'd2
  } hz_state_t;

endpackage

// File: rtl/ex_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// ex_hazard_ctrl_if
// Bundle between the pipeline datapath and the hazard controller.
//   ID fields   : valid_ID, rs1/rs2 address and "used" flags
//   EX fields   : rd_addr_EX, RegWrite_EX, MemRead_EX, Branch_EX, Jump_EX, zero_EX
//   MEM fields  : rd_addr_MEM, RegWrite_MEM, mem_wait
//   Controls    : stage enables, flushes, PC_src, forwarding selects
//   Statistics  : stall_cnt, flush_cnt (CNT_W wide, saturating)
// master = datapath side, slave = controller side.
// ---------------------------------------------------------------------------
interface ex_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  import ex_hazard_pkg::*;

  logic             valid_ID;
  logic [4:0]       rs1_addr_ID;
  logic [4:0]       rs2_addr_ID;
  logic             rs1_used_ID;
  logic             rs2_used_ID;
  logic [4:0]       rd_addr_EX;
  logic             RegWrite_EX;
  logic             MemRead_EX;
  logic             Branch_EX;
  logic             Jump_EX;
  logic             zero_EX;
  logic [4:0]       rd_addr_MEM;
  logic             RegWrite_MEM;
  logic             mem_wait;

  logic             PC_EN;
  logic             IFID_EN;
  logic             IDEX_EN;
  logic             EXMEM_EN;
  logic             IFID_flush;
  logic             IDEX_flush;
  logic             PC_src;
  logic [1:0]       fwd_A_sel;
  logic [1:0]       fwd_B_sel;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output valid_ID, rs1_addr_ID, rs2_addr_ID, rs1_used_ID, rs2_used_ID,
           rd_addr_EX, RegWrite_EX, MemRead_EX, Branch_EX, Jump_EX, zero_EX,
           rd_addr_MEM, RegWrite_MEM, mem_wait,
    input  PC_EN, IFID_EN, IDEX_EN, EXMEM_EN, IFID_flush, IDEX_flush, PC_src,
           fwd_A_sel, fwd_B_sel, stall_cnt, flush_cnt
  );

  modport slave (
    input  valid_ID, rs1_addr_ID, rs2_addr_ID, rs1_used_ID, rs2_used_ID,
           rd_addr_EX, RegWrite_EX, MemRead_EX, Branch_EX, Jump_EX, zero_EX,
           rd_addr_MEM, RegWrite_MEM, mem_wait,
    output PC_EN, IFID_EN, IDEX_EN, EXMEM_EN, IFID_flush, IDEX_flush, PC_src,
           fwd_A_sel, fwd_B_sel, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/ex_hazard_ctrl_fwd_sel_gen.sv
// ---------------------------------------------------------------------------
// fwd_sel_gen
// Combinational forwarding select for one EX operand, computed from the
// instruction currently in ID (it becomes the EX select once registered).
//   valid, addr, used      : ID instruction and this source operand
//   rd_ex, regwrite_ex,
//   memread_ex             : producer now in EX (will be in EX/MEM)
//   rd_mem, regwrite_mem   : producer now in MEM (will be in MEM/WB)
//   sel                    : FWD_RF / FWD_EXMEM / FWD_MEMWB
// ---------------------------------------------------------------------------
module fwd_sel_gen
  import ex_hazard_pkg::*;
(
  input  logic       valid,
  input  logic [4:0] addr,
  input  logic       used,
  input  logic [4:0] rd_ex,
  input  logic       regwrite_ex,
  input  logic       memread_ex,
  input  logic [4:0] rd_mem,
  input  logic       regwrite_mem,
  output logic [1:0] sel
);

  logic active;
  logic hit_ex;
  logic hit_mem;

  assign active = valid & used & (addr != REG_X0);

  // A load in EX cannot forward its data next cycle; that case is handled
  // by the load-use stall, after which the load matches as a MEM producer.
  assign hit_ex  = active & regwrite_ex & ~memread_ex & (rd_ex != REG_X0) & (rd_ex == addr);
  assign hit_mem = active & regwrite_mem & (rd_mem != REG_X0) & (rd_mem == addr);

  // Newer producer (EX) wins over the older one (MEM).
  always_comb begin
    sel = FWD_RF;
    if (hit_ex) begin
      sel = FWD_EXMEM;
    end else if (hit_mem) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/ex_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// ex_hazard_ctrl
// Pipeline sequencing controller around the EX stage.
//   clk, rst : clock and synchronous active-high reset
//   bus      : ex_hazard_ctrl_if.slave (ID/EX/MEM hazard fields in,
//              stage enables, flushes, PC_src, forwarding selects and
//              saturating stall/flush counters out)
// Priority each cycle: rst > memory freeze > taken redirect > load-use stall.
// A redirect that resolves while frozen is remembered in FREEZE_REDIR and
// issued on the release cycle (EX is frozen, so its target is still valid).
// ---------------------------------------------------------------------------
module ex_hazard_ctrl
  import ex_hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  ex_hazard_ctrl_if.slave   bus
);

  hz_state_t        state_reg, state_next;
  logic [1:0]       fwd_sel_reg  [2];
  logic [1:0]       fwd_sel_next [2];
  logic [CNT_W-1:0] stall_cnt_reg;
  logic [CNT_W-1:0] flush_cnt_reg;

  logic take;
  logic lu;
  logic pc_en, ifid_en, idex_en, exmem_en;
  logic ifid_flush, idex_flush, pc_src;
  logic stall_inc, flush_inc;

  // Per-operand ID source fields, indexed 0 = rs1 (A), 1 = rs2 (B).
  logic [4:0] src_addr [2];
  logic       src_used [2];

  assign src_addr[0] = bus.rs1_addr_ID;
  assign src_addr[1] = bus.rs2_addr_ID;
  assign src_used[0] = bus.rs1_used_ID;
  assign src_used[1] = bus.rs2_used_ID;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      fwd_sel_gen u_fwd_sel_gen (
        .valid        (bus.valid_ID),
        .addr         (src_addr[gi]),
        .used         (src_used[gi]),
        .rd_ex        (bus.rd_addr_EX),
        .regwrite_ex  (bus.RegWrite_EX),
        .memread_ex   (bus.MemRead_EX),
        .rd_mem       (bus.rd_addr_MEM),
        .regwrite_mem (bus.RegWrite_MEM),
        .sel          (fwd_sel_next[gi])
      );
    end
  endgenerate

  assign take = (bus.Branch_EX & bus.zero_EX) | bus.Jump_EX;

  assign lu = bus.valid_ID & bus.MemRead_EX & bus.RegWrite_EX &
              (bus.rd_addr_EX != REG_X0) &
              ((bus.rs1_used_ID & (bus.rs1_addr_ID == bus.rd_addr_EX)) |
               (bus.rs2_used_ID & (bus.rs2_addr_ID == bus.rd_addr_EX)));

  // Next state and stage controls. During rst the reset values are driven
  // so the pipeline sees "all enabled, nothing flushed" regardless of inputs.
  always_comb begin
    state_next = state_reg;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pc_src     = 1'b0;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;

    if (rst) begin
      state_next = RUN;
    end else begin
      case (state_reg)
        FREEZE_REDIR: begin
          if (bus.mem_wait) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
          end else begin
            pc_src     = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            flush_inc  = 1'b1;
            state_next = RUN;
          end
        end
        RUN, FREEZE: begin
          if (bus.mem_wait) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            // Only a fresh freeze from RUN can capture a pending redirect.
            if (state_reg == RUN && take) begin
              state_next = FREEZE_REDIR;
            end else begin
              state_next = state_reg;
            end
          end else begin
            // Release from FREEZE evaluates exactly like RUN this cycle.
            state_next = RUN;
            if (take) begin
              pc_src     = 1'b1;
              ifid_flush = 1'b1;
              idex_flush = 1'b1;
              flush_inc  = 1'b1;
            end else if (lu) begin
              pc_en      = 1'b0;
              ifid_en    = 1'b0;
              idex_flush = 1'b1;
              stall_inc  = 1'b1;
            end
          end
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Forwarding selects follow the ID/EX register: bubble on flush,
  // capture on enable, hold while frozen.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          fwd_sel_reg[gi] <= FWD_RF;
        end else if (idex_flush) begin
          fwd_sel_reg[gi] <= FWD_RF;
        end else if (idex_en) begin
          fwd_sel_reg[gi] <= fwd_sel_next[gi];
        end
      end
    end
  endgenerate

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (stall_inc && stall_cnt_reg != {CNT_W{1'b1}}) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
      if (flush_inc && flush_cnt_reg != {CNT_W{1'b1}}) begin
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
      end
    end
  end

  assign bus.PC_EN      = pc_en;
  assign bus.IFID_EN    = ifid_en;
  assign bus.IDEX_EN    = idex_en;
  assign bus.EXMEM_EN   = exmem_en;
  assign bus.IFID_flush = ifid_flush;
  assign bus.IDEX_flush = idex_flush;
  assign bus.PC_src     = pc_src;
  assign bus.fwd_A_sel  = fwd_sel_reg[0];
  assign bus.fwd_B_sel  = fwd_sel_reg[1];
  assign bus.stall_cnt  = stall_cnt_reg;
  assign bus.flush_cnt  = flush_cnt_reg;

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ex_hazard_ctrl
// Directed bench for ex_hazard_ctrl. Counters are built 4 bits wide so
// saturation is reachable in a handful of cycles.
// ctl packs {PC_EN, IFID_EN, IDEX_EN, EXMEM_EN, IFID_flush, IDEX_flush, PC_src}.
// ---------------------------------------------------------------------------
module tb_ex_hazard_ctrl;

  localparam int CNT_W = 4;

  localparam logic [6:0] CTL_RUN    = 7'b1111_000;
  localparam logic [6:0] CTL_FREEZE = 7'b0000_000;
  localparam logic [6:0] CTL_TAKE   = 7'b1111_111;
  localparam logic [6:0] CTL_STALL  = 7'b0011_010;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;

  ex_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  ex_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [6:0] ctl;
  assign ctl = {bus.PC_EN, bus.IFID_EN, bus.IDEX_EN, bus.EXMEM_EN,
                bus.IFID_flush, bus.IDEX_flush, bus.PC_src};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.valid_ID     = 1'b0;
    bus.rs1_addr_ID  = 5'd0;
    bus.rs2_addr_ID  = 5'd0;
    bus.rs1_used_ID  = 1'b0;
    bus.rs2_used_ID  = 1'b0;
    bus.rd_addr_EX   = 5'd0;
    bus.RegWrite_EX  = 1'b0;
    bus.MemRead_EX   = 1'b0;
    bus.Branch_EX    = 1'b0;
    bus.Jump_EX      = 1'b0;
    bus.zero_EX      = 1'b0;
    bus.rd_addr_MEM  = 5'd0;
    bus.RegWrite_MEM = 1'b0;
    bus.mem_wait     = 1'b0;
  endtask

  task automatic set_id(input logic [4:0] a1, input logic u1,
                        input logic [4:0] a2, input logic u2);
    bus.valid_ID    = 1'b1;
    bus.rs1_addr_ID = a1;
    bus.rs1_used_ID = u1;
    bus.rs2_addr_ID = a2;
    bus.rs2_used_ID = u2;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    $display("[TB] reset: ctl=%b fwd=%b/%b cnt=%0d/%0d", ctl, bus.fwd_A_sel,
             bus.fwd_B_sel, bus.stall_cnt, bus.flush_cnt);
    tests_run++;
    if (ctl !== CTL_RUN) begin
      tests_failed++;
      $display("FAIL reset_ctl: got %b want %b", ctl, CTL_RUN);
    end
    tests_run++;
    if ({bus.fwd_A_sel, bus.fwd_B_sel} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_fwd: got %b want 0000", {bus.fwd_A_sel, bus.fwd_B_sel});
    end
    tests_run++;
    if ({bus.stall_cnt, bus.flush_cnt} !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_cnt: got %h want 00", {bus.stall_cnt, bus.flush_cnt});
    end
    // Reset must dominate a simultaneous memory wait.
    bus.mem_wait = 1'b1;
    #1;
    tests_run++;
    if (ctl !== CTL_RUN) begin
      tests_failed++;
      $display("FAIL reset_over_wait: got %b want %b", ctl, CTL_RUN);
    end
    bus.mem_wait = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_forward();
    // add x3, x1, x2 in ID; add x1 in EX.
    clear_inputs();
    set_id(5'd1, 1'b1, 5'd2, 1'b1);
    bus.rd_addr_EX  = 5'd1;
    bus.RegWrite_EX = 1'b1;
    #1;
    tests_run++;
    if (ctl !== CTL_RUN) begin
      tests_failed++;
      $display("FAIL fwd_ex_nostall: got %b want %b", ctl, CTL_RUN);
    end
    tick();
    $display("[TB] fwd_ex: fwd=%b/%b", bus.fwd_A_sel, bus.fwd_B_sel);
    tests_run++;
    if ({bus.fwd_A_sel, bus.fwd_B_sel} !== 4'b0100) begin
      tests_failed++;
      $display("FAIL fwd_ex: got %b want 0100", {bus.fwd_A_sel, bus.fwd_B_sel});
    end
    // EX writes x4, MEM writes x7; ID reads x4 (A) and x7 (B).
    clear_inputs();
    set_id(5'd4, 1'b1, 5'd7, 1'b1);
    bus.rd_addr_EX   = 5'd4;
    bus.RegWrite_EX  = 1'b1;
    bus.rd_addr_MEM  = 5'd7;
    bus.RegWrite_MEM = 1'b1;
    tick();
    $display("[TB] fwd_ex_mem: fwd=%b/%b", bus.fwd_A_sel, bus.fwd_B_sel);
    tests_run++;
    if ({bus.fwd_A_sel, bus.fwd_B_sel} !== 4'b0110) begin
      tests_failed++;
      $display("FAIL fwd_ex_mem: got %b want 0110", {bus.fwd_A_sel, bus.fwd_B_sel});
    end
    // Both producers write x9, ID reads x9 on both operands: newest wins.
    clear_inputs();
    set_id(5'd9, 1'b1, 5'd9, 1'b1);
    bus.rd_addr_EX   = 5'd9;
    bus.RegWrite_EX  = 1'b1;
    bus.rd_addr_MEM  = 5'd9;
    bus.RegWrite_MEM = 1'b1;
    tick();
    $display("[TB] fwd_prio: fwd=%b/%b", bus.fwd_A_sel, bus.fwd_B_sel);
    tests_run++;
    if ({bus.fwd_A_sel, bus.fwd_B_sel} !== 4'b0101) begin
      tests_failed++;
      $display("FAIL fwd_prio: got %b want 0101", {bus.fwd_A_sel, bus.fwd_B_sel});
    end
    // Unused operands do not forward.
    clear_inputs();
    set_id(5'd9, 1'b0, 5'd9, 1'b0);
    bus.rd_addr_EX   = 5'd9;
    bus.RegWrite_EX  = 1'b1;
    tick();
    tests_run++;
    if ({bus.fwd_A_sel, bus.fwd_B_sel} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL fwd_unused: got %b want 0000", {bus.fwd_A_sel, bus.fwd_B_sel});
    end
  endtask

  task automatic test_load_use();
    // lw x5 in EX, add reading x5 in ID.
    clear_inputs();
    set_id(5'd5, 1'b1, 5'd3, 1'b1);
    bus.rd_addr_EX  = 5'd5;
    bus.RegWrite_EX = 1'b1;
    bus.MemRead_EX  = 1'b1;
    #1;
    $display("[TB] load_use: ctl=%b", ctl);
    tests_run++;
    if (ctl !== CTL_STALL) begin
      tests_failed++;
      $display("FAIL lu_ctl: got %b want %b", ctl, CTL_STALL);
    end
    tick();
    tests_run++;
    if (bus.stall_cnt !== 4'd1 || bus.fwd_A_sel !== 2'b00) begin
      tests_failed++;
      $display("FAIL lu_cnt_bubble: got cnt=%0d fwdA=%b want cnt=1 fwdA=00",
               bus.stall_cnt, bus.fwd_A_sel);
    end
    // Load now in MEM, bubble in EX: no second stall, forward from MEM/WB.
    bus.rd_addr_EX   = 5'd0;
    bus.RegWrite_EX  = 1'b0;
    bus.MemRead_EX   = 1'b0;
    bus.rd_addr_MEM  = 5'd5;
    bus.RegWrite_MEM = 1'b1;
    #1;
    tests_run++;
    if (ctl !== CTL_RUN) begin
      tests_failed++;
      $display("FAIL lu_no_second_stall: got %b want %b", ctl, CTL_RUN);
    end
    tick();
    $display("[TB] load_use_after: fwd=%b/%b stall_cnt=%0d", bus.fwd_A_sel,
             bus.fwd_B_sel, bus.stall_cnt);
    tests_run++;
    if ({bus.fwd_A_sel, bus.fwd_B_sel} !== 4'b1000 || bus.stall_cnt !== 4'd1) begin
      tests_failed++;
      $display("FAIL lu_fwd_mem: got fwd=%b cnt=%0d want fwd=1000 cnt=1",
               {bus.fwd_A_sel, bus.fwd_B_sel}, bus.stall_cnt);
    end
  endtask

  task automatic test_take_priority();
    // Not-taken beq: nothing happens.
    clear_inputs();
    bus.Branch_EX = 1'b1;
    bus.zero_EX   = 1'b0;
    #1;
    tests_run++;
    if (ctl !== CTL_RUN) begin
      tests_failed++;
      $display("FAIL beq_not_taken: got %b want %b", ctl, CTL_RUN);
    end
    // Taken beq plus a load-use pattern: redirect wins, no stall counted.
    bus.zero_EX     = 1'b1;
    bus.MemRead_EX  = 1'b1;
    bus.RegWrite_EX = 1'b1;
    bus.rd_addr_EX  = 5'd5;
    set_id(5'd5, 1'b1, 5'd0, 1'b0);
    #1;
    $display("[TB] take_vs_lu: ctl=%b", ctl);
    tests_run++;
    if (ctl !== CTL_TAKE) begin
      tests_failed++;
      $display("FAIL take_ctl: got %b want %b", ctl, CTL_TAKE);
    end
    tick();
    tests_run++;
    if (bus.stall_cnt !== 4'd1 || bus.flush_cnt !== 4'd1) begin
      tests_failed++;
      $display("FAIL take_cnt: got stall=%0d flush=%0d want stall=1 flush=1",
               bus.stall_cnt, bus.flush_cnt);
    end
  endtask

  task automatic test_freeze_redirect();
    // Prime fwd_A=01 so the hold during freeze is observable.
    clear_inputs();
    set_id(5'd1, 1'b1, 5'd0, 1'b0);
    bus.rd_addr_EX  = 5'd1;
    bus.RegWrite_EX = 1'b1;
    tick();
    // jal in EX, memory wait for 3 cycles; ID now reads something else.
    clear_inputs();
    set_id(5'd2, 1'b1, 5'd0, 1'b0);
    bus.Jump_EX     = 1'b1;
    bus.rd_addr_EX  = 5'd1;
    bus.RegWrite_EX = 1'b1;
    bus.mem_wait    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      $display("[TB] freeze_jal cycle %0d: ctl=%b", i, ctl);
      tests_run++;
      if (ctl !== CTL_FREEZE) begin
        tests_failed++;
        $display("FAIL freeze_ctl_%0d: got %b want %b", i, ctl, CTL_FREEZE);
      end
      tick();
    end
    tests_run++;
    if (bus.fwd_A_sel !== 2'b01) begin
      tests_failed++;
      $display("FAIL freeze_fwd_hold: got %b want 01", bus.fwd_A_sel);
    end
    // Release: held redirect issues now.
    bus.mem_wait = 1'b0;
    #1;
    $display("[TB] freeze_release: ctl=%b", ctl);
    tests_run++;
    if (ctl !== CTL_TAKE) begin
      tests_failed++;
      $display("FAIL release_redirect: got %b want %b", ctl, CTL_TAKE);
    end
    tick();
    tests_run++;
    if (bus.flush_cnt !== 4'd2) begin
      tests_failed++;
      $display("FAIL release_flush_cnt: got %0d want 2", bus.flush_cnt);
    end
    // Back in RUN with nothing pending.
    clear_inputs();
    #1;
    tests_run++;
    if (ctl !== CTL_RUN) begin
      tests_failed++;
      $display("FAIL after_release: got %b want %b", ctl, CTL_RUN);
    end
    // Plain freeze, released with a load-use present: stall applies that cycle.
    bus.mem_wait = 1'b1;
    tick();
    bus.mem_wait    = 1'b0;
    bus.MemRead_EX  = 1'b1;
    bus.RegWrite_EX = 1'b1;
    bus.rd_addr_EX  = 5'd6;
    set_id(5'd0, 1'b0, 5'd6, 1'b1);
    #1;
    $display("[TB] freeze_release_lu: ctl=%b", ctl);
    tests_run++;
    if (ctl !== CTL_STALL) begin
      tests_failed++;
      $display("FAIL release_lu: got %b want %b", ctl, CTL_STALL);
    end
    tick();
    tests_run++;
    if (bus.stall_cnt !== 4'd2 || bus.flush_cnt !== 4'd2) begin
      tests_failed++;
      $display("FAIL release_lu_cnt: got stall=%0d flush=%0d want 2/2",
               bus.stall_cnt, bus.flush_cnt);
    end
  endtask

  task automatic test_x0();
    // Load writing x0 in EX, MEM writing x0, ID reads x0 twice.
    clear_inputs();
    set_id(5'd0, 1'b1, 5'd0, 1'b1);
    bus.MemRead_EX   = 1'b1;
    bus.RegWrite_EX  = 1'b1;
    bus.rd_addr_MEM  = 5'd0;
    bus.RegWrite_MEM = 1'b1;
    #1;
    tests_run++;
    if (ctl !== CTL_RUN) begin
      tests_failed++;
      $display("FAIL x0_no_stall: got %b want %b", ctl, CTL_RUN);
    end
    // Non-load write to x0 in EX.
    bus.MemRead_EX = 1'b0;
    tick();
    $display("[TB] x0: fwd=%b/%b", bus.fwd_A_sel, bus.fwd_B_sel);
    tests_run++;
    if ({bus.fwd_A_sel, bus.fwd_B_sel} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL x0_fwd: got %b want 0000", {bus.fwd_A_sel, bus.fwd_B_sel});
    end
    // valid_ID=0 suppresses load-use.
    clear_inputs();
    bus.rs1_addr_ID = 5'd5;
    bus.rs1_used_ID = 1'b1;
    bus.rd_addr_EX  = 5'd5;
    bus.MemRead_EX  = 1'b1;
    bus.RegWrite_EX = 1'b1;
    #1;
    tests_run++;
    if (ctl !== CTL_RUN) begin
      tests_failed++;
      $display("FAIL invalid_id_no_stall: got %b want %b", ctl, CTL_RUN);
    end
  endtask

  task automatic test_reset_mid_freeze();
    clear_inputs();
    bus.mem_wait = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    tests_run++;
    if (ctl !== CTL_RUN) begin
      tests_failed++;
      $display("FAIL rst_in_freeze_ctl: got %b want %b", ctl, CTL_RUN);
    end
    tick();
    rst = 1'b0;
    bus.mem_wait = 1'b0;
    #1;
    $display("[TB] reset_mid_freeze: ctl=%b cnt=%0d/%0d", ctl, bus.stall_cnt, bus.flush_cnt);
    tests_run++;
    if (ctl !== CTL_RUN || bus.stall_cnt !== 4'd0 || bus.flush_cnt !== 4'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_freeze: got ctl=%b cnt=%0d/%0d want %b 0/0",
               ctl, bus.stall_cnt, bus.flush_cnt, CTL_RUN);
    end
    tick();
  endtask

  task automatic test_saturate();
    clear_inputs();
    set_id(5'd8, 1'b1, 5'd0, 1'b0);
    bus.rd_addr_EX  = 5'd8;
    bus.MemRead_EX  = 1'b1;
    bus.RegWrite_EX = 1'b1;
    for (int i = 0; i < 14; i++) tick();
    tests_run++;
    if (bus.stall_cnt !== 4'd14) begin
      tests_failed++;
      $display("FAIL sat_pre: got %0d want 14", bus.stall_cnt);
    end
    for (int i = 0; i < 6; i++) tick();
    $display("[TB] saturate: stall_cnt=%0d", bus.stall_cnt);
    tests_run++;
    if (bus.stall_cnt !== 4'd15) begin
      tests_failed++;
      $display("FAIL sat_hold: got %0d want 15", bus.stall_cnt);
    end
    clear_inputs();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    clear_inputs();
    test_reset();
    test_forward();
    test_load_use();
    test_take_priority();
    test_freeze_redirect();
    test_x0();
    test_reset_mid_freeze();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
